// File: rtl/dmem_responder_if.sv
// Request/response bus between an initiator (ALU side) and the data-memory responder.
interface dmem_responder_if;
    logic [31:0] addr;
    logic [31:0] wrData;
    logic        wrMem;
    logic        rdMem;
    logic [31:0] rdData;
    logic        ready;
    logic        err;

    modport master (
        output addr, wrData, wrMem, rdMem,
        input  rdData, ready, err
    );

    modport slave (
        input  addr, wrData, wrMem, rdMem,
        output rdData, ready, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory that answers each accepted request after a fixed LATENCY
// with a one-cycle ready strobe, flagging out-of-range and read/write-conflict requests.
module dmem_responder #(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = 2
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e        r_state;
    logic [3:0]    r_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_rd;
    logic          r_wr;
    logic          r_ready;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH];

    logic          w_oob;
    logic          w_conflict;
    logic [AW-1:0] w_idx;

    // Full 32-bit compare so high address bits never alias into the array.
    assign w_oob      = (r_addr >= DEPTH);
    assign w_conflict = r_rd & r_wr;
    assign w_idx      = r_addr[AW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                StIdle: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    if (bus.rdMem || bus.wrMem) begin
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wrData;
                        r_rd    <= bus.rdMem;
                        r_wr    <= bus.wrMem;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_state <= StBusy;
                    end
                end
                StBusy: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= StResp;
                        r_ready <= 1'b1;
                        r_err   <= w_oob | w_conflict;
                        // Memory and rdData commit only on the edge that enters RESP.
                        if (!w_conflict && !w_oob) begin
                            if (r_wr) r_mem[w_idx] <= r_wdata;
                            if (r_rd) r_rdata <= r_mem[w_idx];
                        end else if (!w_conflict && r_rd) begin
                            r_rdata <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StResp: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.rdData = r_rdata;
    assign bus.ready  = r_ready;
    assign bus.err    = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Random and directed transactions on LATENCY=2 and LATENCY=1 responders,
// checked against an array-based memory model.
module tb_dmem_responder;
    localparam int unsigned DEPTH = 128;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic [31:0] mdl_mem [2][DEPTH];
    logic [31:0] mdl_rd [2];

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input int sel, input logic [31:0] a, input logic [31:0] d,
                         input logic rd, input logic wr);
        if (sel == 0) begin
            bus0.addr = a; bus0.wrData = d; bus0.rdMem = rd; bus0.wrMem = wr;
        end else begin
            bus1.addr = a; bus1.wrData = d; bus1.rdMem = rd; bus1.wrMem = wr;
        end
    endtask

    task automatic sample(input int sel, output logic rdy, output logic er,
                          output logic [31:0] rdd);
        if (sel == 0) begin
            rdy = bus0.ready; er = bus0.err; rdd = bus0.rdData;
        end else begin
            rdy = bus1.ready; er = bus1.err; rdd = bus1.rdData;
        end
    endtask

    task automatic mdl_clear();
        for (int s = 0; s < 2; s++) begin
            mdl_rd[s] = '0;
            for (int i = 0; i < int'(DEPTH); i++) mdl_mem[s][i] = '0;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        logic rdy, er;
        logic [31:0] rdd;
        for (int s = 0; s < 2; s++) begin
            sample(s, rdy, er, rdd);
            check_eq({tag, "_rdy"}, {31'b0, rdy}, 32'd0);
            check_eq({tag, "_err"}, {31'b0, er}, 32'd0);
            check_eq({tag, "_data"}, rdd, 32'd0);
        end
    endtask

    // One request: accept, LATENCY edges to the ready cycle, then back to idle.
    task automatic txn(input int sel, input logic [31:0] a, input logic [31:0] d,
                       input logic rd, input logic wr, input bit hold);
        int lat;
        logic rdy, er, inr, exp_err;
        logic [31:0] rdd, exp_rd;
        lat     = (sel == 0) ? 2 : 1;
        inr     = (a < DEPTH);
        exp_err = (rd & wr) | ~inr;
        exp_rd  = mdl_rd[sel];
        if (rd && !wr) exp_rd = inr ? mdl_mem[sel][a[6:0]] : 32'd0;

        @(negedge clk);
        drive(sel, a, d, rd, wr);
        @(posedge clk);
        #1;
        sample(sel, rdy, er, rdd);
        check_eq("accept_rdy", {31'b0, rdy}, 32'd0);
        if (!hold) drive(sel, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk);
            #1;
            sample(sel, rdy, er, rdd);
            if (i < lat) begin
                check_eq("busy_rdy", {31'b0, rdy}, 32'd0);
                check_eq("busy_err", {31'b0, er}, 32'd0);
            end else begin
                check_eq("resp_rdy", {31'b0, rdy}, 32'd1);
                check_eq("resp_err", {31'b0, er}, {31'b0, exp_err});
                check_eq("resp_data", rdd, exp_rd);
            end
        end
        @(posedge clk);
        #1;
        sample(sel, rdy, er, rdd);
        check_eq("post_rdy", {31'b0, rdy}, 32'd0);
        check_eq("post_err", {31'b0, er}, 32'd0);
        check_eq("post_data", rdd, exp_rd);
        if (hold) begin
            drive(sel, 32'd0, 32'd0, 1'b0, 1'b0);
            repeat (lat + 1) begin
                @(posedge clk);
                #1;
                sample(sel, rdy, er, rdd);
                check_eq("reaccept_rdy", {31'b0, rdy}, 32'd0);
            end
        end
        if (wr && !rd && inr) mdl_mem[sel][a[6:0]] = d;
        mdl_rd[sel] = exp_rd;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'(DEPTH) + 32'($urandom_range(0, 1000));
        if (r == 1) return (32'($urandom_range(1, 65535)) << 16) | 32'($urandom_range(0, 127));
        if (r < 6)  return 32'($urandom_range(0, 15));
        return 32'($urandom_range(0, 127));
    endfunction

    initial begin
        logic rdy, er;
        logic [31:0] rdd;
        drive(0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1, 32'd0, 32'd0, 1'b0, 1'b0);
        mdl_clear();
        #3;
        check_idle_outputs("rst0");
        @(negedge clk);
        rst = 1'b1;

        txn(0, 32'd3, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        txn(0, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_idle_outputs("rst_mid");
        mdl_clear();
        @(negedge clk);
        rst = 1'b1;
        txn(0, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0);
        txn(0, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0);

        txn(0, 32'd7, 32'hA5A5_5A5A, 1'b0, 1'b1, 1'b0);
        txn(0, 32'd7, 32'd0, 1'b1, 1'b0, 1'b0);
        txn(0, 32'd128, 32'd0, 1'b1, 1'b0, 1'b0);
        txn(0, 32'd7, 32'd0, 1'b1, 1'b0, 1'b0);
        txn(0, 32'd7, 32'hFFFF_0000, 1'b1, 1'b1, 1'b0);
        txn(0, 32'd7, 32'd0, 1'b1, 1'b0, 1'b0);
        txn(0, 32'h0001_0007, 32'h1111_2222, 1'b0, 1'b1, 1'b0);
        txn(0, 32'd7, 32'd0, 1'b1, 1'b0, 1'b0);

        txn(0, 32'd20, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1);
        txn(0, 32'd20, 32'd0, 1'b1, 1'b0, 1'b0);

        // Reset while the write to addr 9 is still in BUSY.
        @(negedge clk);
        drive(0, 32'd9, 32'h1234_5678, 1'b0, 1'b1);
        @(posedge clk);
        #1 drive(0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1 sample(0, rdy, er, rdd);
            check_eq("abort_rdy", {31'b0, rdy}, 32'd0);
        end
        mdl_clear();
        @(negedge clk);
        rst = 1'b1;
        txn(0, 32'd9, 32'd0, 1'b1, 1'b0, 1'b0);

        txn(1, 32'd11, 32'h0BAD_CAFE, 1'b0, 1'b1, 1'b0);
        txn(1, 32'd11, 32'd0, 1'b1, 1'b0, 1'b0);
        txn(1, 32'd200, 32'd0, 1'b1, 1'b0, 1'b0);
        txn(1, 32'd11, 32'h7777_7777, 1'b0, 1'b1, 1'b1);
        txn(1, 32'd11, 32'd0, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            int unsigned k;
            logic rd, wr;
            k  = $urandom_range(0, 7);
            rd = (k == 0) || (k > 3);
            wr = (k < 4);
            txn(int'($urandom_range(0, 1)), rand_addr(), $urandom, rd, wr,
                ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
